serial_rx_package: RTL
======================

// Module: serial_rx_package
// PURPOSE
//  Receive side of the packaged serial link: the far-end counterpart of the TX package stage.
//  Deserialises 8N1 UART frames from the rx line and assembles 2**AddressWidth words into one package.
//  Word order: the first word received is the most significant word, matching the TX stage.
//  Presents the package with a one-cycle valid strobe to downstream logic.
//  Drops malformed or stale partial packages, so package alignment recovers without a reset.
// PARAMETERS
//  AddressWidth  2   log2(words per package); package width = 2**AddressWidth*WordWidth
//  WordWidth     8   data bits per serial frame, LSB first
//  ClocksPerBit  16  clk cycles per bit period; must equal the TX bit period; even, >=4
//  TimeoutBits   8   idle bit periods allowed between words before a partial package is dropped
// PORTS
//  clk         in   1                           system clock; all state on posedge
//  rst         in   1                           asynchronous reset, ACTIVE-LOW (0 = reset)
//  rx          in   1                           serial line; idle high; asynchronous to clk
//  data        out  2**AddressWidth*WordWidth   last complete package; held until the next one
//  valid       out  1                           one-cycle pulse when data updates
//  frameError  out  1                           one-cycle pulse on a stop bit sampled 0
//  dropped     out  1                           one-cycle pulse when a partial package is discarded by timeout
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE; word index=0; timers=0.
//   data=0; valid=frameError=dropped=0; synchroniser flops=1.
//  rx passes through a 2-flop synchroniser; all decisions use the synchronised value.
//  Byte FSM:
//   IDLE  -> START on sync rx=0.
//   START -> wait ClocksPerBit/2, resample. If 0 -> DATA; if 1 -> IDLE (glitch, nothing reported).
//   DATA  -> sample every ClocksPerBit; shift in LSB first; after WordWidth samples -> STOP.
//   STOP  -> sample after ClocksPerBit.
//            If 1: byte accepted -> IDLE.
//            If 0: pulse frameError; discard the partial package (index=0); -> BREAK.
//   BREAK -> stay until sync rx=1, then -> IDLE.
//  Assembly:
//   - The accepted byte is written to word slot (2**AddressWidth-1-index); index increments.
//   - If index was 2**AddressWidth-1, the complete package is copied to data, valid pulses on
//     the next cycle, and index wraps to 0.
//   - data never shows a partial package.
//  Latency: valid is asserted 2 clk after the mid-stop-bit sample of the last word.
//  Timeout: when index!=0 and FSM is IDLE, count clocks.
//   At TimeoutBits*ClocksPerBit: index=0, pulse dropped once.
//   A START resets the counter. No timeout counting while index=0.
//  Simultaneous events: frameError and dropped never pulse in the same cycle.
//   A timeout and a start-bit detect in the same cycle: the timeout wins, and the new byte becomes word 0.
//  Timer width is $clog2(TimeoutBits*ClocksPerBit+1); the bit counter wraps only through FSM control.
//  Reset mid-frame: immediate return to reset state; the next complete frame starts a new package.
//  No backpressure: a new package overwrites data; downstream must capture on valid.
// STRUCTURE
//  Shared package/header: FSM state encodings (IDLE, START, DATA, STOP, BREAK) and a
//   clog2 helper macro, reused by the TX side.
//  Natural sub-module: SerialRx in io/. It is the byte receiver: synchroniser + FSM, with
//   outputs Q[WordWidth-1:0], done pulse, frameError pulse.
//  This module adds the word index, assembly register, timeout counter and output strobes.
// TESTING (ClocksPerBit=16, AddressWidth=2, WordWidth=8, TimeoutBits=8)
//  1. Frames 0xDE,0xAD,0xBE,0xEF back-to-back -> data=32'hDEADBEEF, a single valid pulse, no errors.
//  2. rx low for 4 clk in IDLE -> no byte. Then 0x01,0x02,0x03,0x04 -> data=32'h01020304.
//  3. 2nd frame has stop bit=0 -> frameError pulses once, data unchanged. Hold rx high, then
//     0xA1,0xB2,0xC3,0xD4 -> data=32'hA1B2C3D4.
//  4. Send 0x55,0x66, then idle 10 bit periods -> dropped pulses after 8 periods.
//     Then 0x11,0x22,0x33,0x44 -> data=32'h11223344.
//  5. Assert rst=0 during the data bits of the 3rd word -> all outputs 0. Release, then
//     0xCA,0xFE,0xF0,0x0D -> data=32'hCAFEF00D.
//  6. Loopback from the TX package stage: push 32'h12345678 and 32'h9ABCDEF0 -> two valid
//     pulses, with matching data in order.

Source files
------------

// File: rtl/serial_rx_package_pkg.sv
// Shared definitions for the packaged serial link: byte-receiver state encodings
// and a width helper reused by the TX side.
package serial_rx_package_pkg;

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StStart = 3'd1;
    localparam logic [2:0] StData  = 3'd2;
    localparam logic [2:0] StStop  = 3'd3;
    localparam logic [2:0] StBreak = 3'd4;

    // Counter width for values 0..value-1, never narrower than one bit.
    function automatic int clog2Min1(input int value);
        int w;
        w = $clog2(value);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/serial_rx_package_serial_rx.sv
// 8N1 byte receiver: two-flop synchroniser on rx plus the start/data/stop/break FSM.
// Emits one-cycle done or frameError pulses; state is exported for debug visibility.
module serial_rx_package_serial_rx
    import serial_rx_package_pkg::*;
#(
    parameter int WordWidth    = 8,
    parameter int ClocksPerBit = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [WordWidth-1:0] q,
    output logic                 done,
    output logic                 frameError,
    output logic                 startDetect,
    output logic [2:0]           state
);

    localparam int CntWidth = clog2Min1(ClocksPerBit);
    localparam int BitWidth = clog2Min1(WordWidth);
    localparam logic [CntWidth-1:0] HalfLast = CntWidth'(ClocksPerBit / 2 - 1);
    localparam logic [CntWidth-1:0] BitLast  = CntWidth'(ClocksPerBit - 1);
    localparam logic [BitWidth-1:0] WordLast = BitWidth'(WordWidth - 1);

    logic                 rxMeta;
    logic                 rxSync;
    logic [CntWidth-1:0]  clkCnt;
    logic [BitWidth-1:0]  bitCnt;
    logic [WordWidth-1:0] shiftReg;

    assign startDetect = (state == StIdle) && !rxSync;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rxMeta <= 1'b1;
            rxSync <= 1'b1;
        end else begin
            rxMeta <= rx;
            rxSync <= rxMeta;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= StIdle;
            clkCnt     <= '0;
            bitCnt     <= '0;
            shiftReg   <= '0;
            q          <= '0;
            done       <= 1'b0;
            frameError <= 1'b0;
        end else begin
            done       <= 1'b0;
            frameError <= 1'b0;
            case (state)
                StIdle: begin
                    clkCnt <= '0;
                    if (!rxSync) state <= StStart;
                end
                // Resample half a bit in; a line already back high was a glitch.
                StStart: begin
                    if (clkCnt == HalfLast) begin
                        clkCnt <= '0;
                        bitCnt <= '0;
                        state  <= rxSync ? StIdle : StData;
                    end else begin
                        clkCnt <= clkCnt + 1'b1;
                    end
                end
                StData: begin
                    if (clkCnt == BitLast) begin
                        clkCnt   <= '0;
                        shiftReg <= {rxSync, shiftReg[WordWidth-1:1]};
                        if (bitCnt == WordLast) state <= StStop;
                        else bitCnt <= bitCnt + 1'b1;
                    end else begin
                        clkCnt <= clkCnt + 1'b1;
                    end
                end
                StStop: begin
                    if (clkCnt == BitLast) begin
                        clkCnt <= '0;
                        if (rxSync) begin
                            done  <= 1'b1;
                            q     <= shiftReg;
                            state <= StIdle;
                        end else begin
                            frameError <= 1'b1;
                            state      <= StBreak;
                        end
                    end else begin
                        clkCnt <= clkCnt + 1'b1;
                    end
                end
                StBreak: begin
                    if (rxSync) state <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: rtl/serial_rx_package.sv
// Receive side of the packaged serial link: assembles 2**AddressWidth received words,
// first word most significant, and strobes the completed package out on valid.
module serial_rx_package
    import serial_rx_package_pkg::*;
#(
    parameter int AddressWidth = 2,
    parameter int WordWidth    = 8,
    parameter int ClocksPerBit = 16,
    parameter int TimeoutBits  = 8
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  rx,
    output logic [(2**AddressWidth)*WordWidth-1:0] data,
    output logic                                  valid,
    output logic                                  frameError,
    output logic                                  dropped
);

    localparam int Words         = 2**AddressWidth;
    localparam int PkgWidth      = Words * WordWidth;
    localparam int TimeoutClocks = TimeoutBits * ClocksPerBit;
    localparam int TimerWidth    = $clog2(TimeoutClocks + 1);
    localparam logic [AddressWidth-1:0] LastIdx   = '1;
    localparam logic [TimerWidth-1:0]   TimerLast = TimerWidth'(TimeoutClocks - 1);

    logic [WordWidth-1:0]    byteQ;
    logic                    byteDone;
    logic                    byteFrameError;
    logic                    startDetect;
    logic [2:0]              rxState;
    logic [AddressWidth-1:0] index;
    logic [AddressWidth-1:0] slot;
    logic [PkgWidth-1:0]     pkgBuf;
    logic                    pkgReady;
    logic [TimerWidth-1:0]   timer;
    logic                    counting;

    serial_rx_package_serial_rx #(
        .WordWidth   (WordWidth),
        .ClocksPerBit(ClocksPerBit)
    ) u_serial_rx (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .q          (byteQ),
        .done       (byteDone),
        .frameError (byteFrameError),
        .startDetect(startDetect),
        .state      (rxState)
    );

    // frameError comes from STOP and dropped needs IDLE, so they never coincide.
    assign frameError = byteFrameError;
    assign slot       = LastIdx - index;
    // A start detect leaves IDLE on the same edge, so a coincident timeout still wins.
    assign counting   = (index != '0) && (rxState == StIdle);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            index    <= '0;
            pkgBuf   <= '0;
            pkgReady <= 1'b0;
            data     <= '0;
            valid    <= 1'b0;
            dropped  <= 1'b0;
            timer    <= '0;
        end else begin
            valid    <= 1'b0;
            dropped  <= 1'b0;
            pkgReady <= 1'b0;

            // Staging through pkgBuf keeps partial packages off data.
            if (pkgReady) begin
                data  <= pkgBuf;
                valid <= 1'b1;
            end

            if (byteDone) begin
                pkgBuf[slot*WordWidth +: WordWidth] <= byteQ;
                index <= index + 1'b1;
                if (index == LastIdx) pkgReady <= 1'b1;
            end else if (byteFrameError) begin
                index <= '0;
            end

            if (!counting) begin
                timer <= '0;
            end else if (timer == TimerLast) begin
                timer   <= '0;
                index   <= '0;
                dropped <= 1'b1;
            end else begin
                timer <= timer + 1'b1;
            end
        end
    end

endmodule
